layer_conv_sequencer: RTL

Sequences one 3x3 convolution layer pass. The block reads each pixel of the input feature buffer in raster order and drives `valid_in` of every featuremap instance in the layer in lockstep. It marks pixels whose full 3x3 window lies inside the image, then flushes the featuremap pipeline before signalling completion. It sits between the layer-level top controller (`start`/`done`) and the input feature-buffer RAM plus the featuremap array.

---
 rtl/layer_conv_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/layer_conv_sequencer.sv
// Sequencer for one 3x3 convolution layer pass: raster-reads the input buffer,
// tags pixels with a full 3x3 window, then drains the featuremap pipeline.
module layer_conv_sequencer #(
  parameter int IMG_SIZE   = 104,
  parameter int ADDR_WIDTH = 14,
  parameter int PIPE_LAT   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  fm_valid_in,
  output logic                  win_valid,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  win_count
);

  localparam int N       = IMG_SIZE * IMG_SIZE;
  localparam int RC_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int DRAIN_W = 9;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N - 1);
  localparam logic [RC_W-1:0]       LAST_COL   = RC_W'(IMG_SIZE - 1);
  localparam logic [RC_W-1:0]       RC_TWO     = RC_W'(2);
  localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [RC_W-1:0]        row_q, row_d;
  logic [RC_W-1:0]        col_q, col_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic                   fm_valid_q, fm_valid_d;
  logic                   win_valid_q, win_valid_d;
  logic [CNT_WIDTH-1:0]   win_count_q, win_count_d;
  logic                   start_acc_s;

  // State register plus datapath flops
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drain_q     <= '0;
      fm_valid_q  <= 1'b0;
      win_valid_q <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drain_q     <= drain_d;
      fm_valid_q  <= fm_valid_d;
      win_valid_q <= win_valid_d;
      win_count_q <= win_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (rd_en && (rd_addr_q == LAST_ADDR)) state_d = S_DRAIN;
        else                                   state_d = S_RUN;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(1)) state_d = S_IDLE;
        else                        state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    start_acc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_acc_s = start;
      end
      S_RUN: begin
        busy  = 1'b1;
        rd_en = ~stall;
      end
      S_DRAIN: begin
        busy = 1'b1;
        done = (drain_q == DRAIN_W'(1));
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Address/raster counters, delay stage, window count and drain timer
  always_comb begin
    rd_addr_d   = rd_addr_q;
    row_d       = row_q;
    col_d       = col_q;
    fm_valid_d  = rd_en;
    win_valid_d = rd_en & (row_q >= RC_TWO) & (col_q >= RC_TWO);
    win_count_d = win_count_q;
    drain_d     = '0;

    if (start_acc_s) begin
      rd_addr_d = '0;
      row_d     = '0;
      col_d     = '0;
    end else if (rd_en) begin
      rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end else begin
      rd_addr_d = rd_addr_q;
    end

    if (start_acc_s)      win_count_d = '0;
    else if (win_valid_q) win_count_d = win_count_q + CNT_WIDTH'(1);
    else                  win_count_d = win_count_q;

    // The first DRAIN cycle loads the timer; done fires when it reaches 1.
    if (state_q == S_DRAIN) begin
      if (drain_q == '0) drain_d = DRAIN_LOAD;
      else               drain_d = drain_q - DRAIN_W'(1);
    end else begin
      drain_d = '0;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign fm_valid_in = fm_valid_q;
  assign win_valid   = win_valid_q;
  assign win_count   = win_count_q;

endmodule
